// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory among fetch, data and host requesters,
// with fetch anti-starvation, host burst locking and one-cycle read-return routing.
module mem_port_arbiter #(
  parameter int AW = 10,
  parameter int DW = 16,
  parameter int MAX_STALL = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  output logic          f_gnt,
  output logic          f_rvalid,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  input  logic          h_req,
  input  logic          h_we,
  input  logic [AW-1:0] h_addr,
  input  logic [DW-1:0] h_wdata,
  input  logic          h_lock,
  output logic          h_gnt,
  output logic          h_rvalid,
  output logic [DW-1:0] rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);
  localparam int SW = $clog2(MAX_STALL + 1);
  localparam logic [0:0] ARB = 1'b0;
  localparam logic [0:0] LOCK = 1'b1;
  logic [0:0]    state;
  logic [SW-1:0] stall_cnt;
  logic          rr_last;
  logic          force_f;
  logic          arb;
  // rr_last: 0 = fetch won last, 1 = host won last
  assign arb     = !reset && state == ARB;
  assign force_f = arb && f_req && stall_cnt == SW'(MAX_STALL);
  assign f_gnt   = force_f || (arb && !d_req && f_req && (!h_req || rr_last));
  assign d_gnt   = arb && !force_f && d_req;
  assign h_gnt   = !reset && h_req &&
                   (state == LOCK || (arb && !force_f && !d_req && (!f_req || !rr_last)));
  assign mem_en    = f_gnt || d_gnt || h_gnt;
  assign mem_we    = (d_gnt && d_we) || (h_gnt && h_we);
  assign mem_addr  = f_gnt ? f_addr : d_gnt ? d_addr : h_gnt ? h_addr : '0;
  assign mem_wdata = d_gnt ? d_wdata : h_gnt ? h_wdata : '0;
  assign rdata     = (f_rvalid || d_rvalid || h_rvalid) ? mem_rdata : '0;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ARB;
      stall_cnt <= '0;
      rr_last   <= 1'b0;
      f_rvalid  <= 1'b0;
      d_rvalid  <= 1'b0;
      h_rvalid  <= 1'b0;
    end else begin
      state     <= state == ARB ? ((h_gnt && h_lock) ? LOCK : ARB) : ((h_lock && h_req) ? LOCK : ARB);
      stall_cnt <= (f_gnt || !f_req) ? '0 :
                   stall_cnt == SW'(MAX_STALL) ? stall_cnt : stall_cnt + SW'(1);
      rr_last   <= f_gnt ? 1'b0 : h_gnt ? 1'b1 : rr_last;
      f_rvalid  <= f_gnt;
      d_rvalid  <= d_gnt && !d_we;
      h_rvalid  <= h_gnt && !h_we;
    end
  end
endmodule
